// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the bit-serial adder/subtractor.
// The FSM state type and the step/counter sizing live here so the top and bench agree.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN cycles needed to sweep the whole operand.
    function automatic int calc_steps(input int width, input int bits_per_cycle);
        return width / bits_per_cycle;
    endfunction

    // Step counter must be able to hold the value STEPS.
    function automatic int cnt_width(input int steps);
        return $clog2(steps + 1);
    endfunction

endpackage

// File: rtl/serial_adder_bit_cell.sv
// One full-adder bit cell; a chain of these forms the per-cycle ripple slice.
module adder_bit_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: a +/- b +/- cin, BITS_PER_CYCLE bits per step, LSB first.
// One ripple slice is reused every cycle; the carry is held in a register between steps.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int BPC   = BITS_PER_CYCLE;
    localparam int STEPS = calc_steps(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = cnt_width(STEPS);

    generate
        if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_param_check
            $error("serial_adder: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
        end
    endgenerate

    state_t             state_reg;
    logic [CNT_W-1:0]   step_reg;
    logic [WIDTH-1:0]   a_sh_reg;
    logic [WIDTH-1:0]   b_sh_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               carry_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;
    logic               cout_reg;
    logic               overflow_reg;

    logic [BPC:0]       chain;
    logic [BPC-1:0]     slice_sum;
    logic [WIDTH+BPC-1:0] result_cat;
    logic [WIDTH-1:0]   result_next;

    assign chain[0] = carry_reg;

    generate
        for (genvar gi = 0; gi < BPC; gi++) begin : g_cell
            adder_bit_cell u_cell (
                .a  (a_sh_reg[gi]),
                .b  (b_sh_reg[gi]),
                .ci (chain[gi]),
                .s  (slice_sum[gi]),
                .co (chain[gi+1])
            );
        end
    endgenerate

    // New slice enters at the top; after STEPS shifts the LSB slice sits at bit 0.
    assign result_cat  = {slice_sum, result_reg};
    assign result_next = result_cat[WIDTH+BPC-1:BPC];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            step_reg      <= '0;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            result_reg    <= '0;
            carry_reg     <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            cout_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    in_ready_reg <= 1'b1;
                    if (in_valid && in_ready_reg) begin
                        // Subtraction is a + ~b + ~borrow.
                        a_sh_reg     <= a;
                        b_sh_reg     <= sub ? ~b : b;
                        carry_reg    <= cin ^ sub;
                        step_reg     <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    result_reg <= result_next;
                    a_sh_reg   <= a_sh_reg >> BPC;
                    b_sh_reg   <= b_sh_reg >> BPC;
                    carry_reg  <= chain[BPC];
                    if (step_reg == CNT_W'(STEPS - 1)) begin
                        step_reg      <= '0;
                        cout_reg      <= chain[BPC];
                        overflow_reg  <= chain[BPC-1] ^ chain[BPC];
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        step_reg <= step_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    in_ready_reg  <= 1'b0;
                    out_valid_reg <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign sum       = result_reg;
    assign cout      = cout_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit/1-bit-per-cycle and a 16-bit/4-bit-per-cycle instance.
// Drivers push hand-computed expectations; per-instance monitors pop and compare on each result handshake.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid8 = 1'b0, out_ready8 = 1'b1, cin8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       in_ready8, out_valid8, cout8, ovf8;
    logic [7:0] sum8;

    logic        in_valid16 = 1'b0, out_ready16 = 1'b1, cin16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        in_ready16, out_valid16, cout16, ovf16;
    logic [15:0] sum16;

    serial_adder #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    serial_adder #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .overflow(ovf16)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic ov8_prev = 1'b0, ov16_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor for the 8-bit instance
    always @(negedge clk) begin
        if (out_valid8 && !ov8_prev && q8.size() > 0) begin
            n_checks++;
            if (cyc - q8[0].acc != 8) begin
                n_fail++;
                $display("FAIL latency8: got %0d cycles, expected 8", cyc - q8[0].acc);
            end
        end
        if (out_valid8 && out_ready8) begin
            n_checks++;
            if (q8.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected8: result sum=0x%0h with nothing outstanding", sum8);
            end else begin
                e8 = q8.pop_front();
                if (sum8 !== e8.sum[7:0] || cout8 !== e8.cout || ovf8 !== e8.ovf) begin
                    n_fail++;
                    $display("FAIL result8: got sum=0x%0h cout=%b ovf=%b, expected sum=0x%0h cout=%b ovf=%b",
                             sum8, cout8, ovf8, e8.sum[7:0], e8.cout, e8.ovf);
                end else begin
                    $display("txn8  sum=0x%02h cout=%b ovf=%b ok", sum8, cout8, ovf8);
                end
            end
        end
        ov8_prev = out_valid8;
    end

    // Monitor for the 16-bit instance
    always @(negedge clk) begin
        if (out_valid16 && !ov16_prev && q16.size() > 0) begin
            n_checks++;
            if (cyc - q16[0].acc != 4) begin
                n_fail++;
                $display("FAIL latency16: got %0d cycles, expected 4", cyc - q16[0].acc);
            end
        end
        if (out_valid16 && out_ready16) begin
            n_checks++;
            if (q16.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected16: result sum=0x%0h with nothing outstanding", sum16);
            end else begin
                e16 = q16.pop_front();
                if (sum16 !== e16.sum || cout16 !== e16.cout || ovf16 !== e16.ovf) begin
                    n_fail++;
                    $display("FAIL result16: got sum=0x%0h cout=%b ovf=%b, expected sum=0x%0h cout=%b ovf=%b",
                             sum16, cout16, ovf16, e16.sum, e16.cout, e16.ovf);
                end else begin
                    $display("txn16 sum=0x%04h cout=%b ovf=%b ok", sum16, cout16, ovf16);
                end
            end
        end
        ov16_prev = out_valid16;
    end

    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic c, input logic s,
                          input bit expect_it, input logic [7:0] es, input logic ec, input logic eo);
        exp_t e;
        int   t;
        @(posedge clk); #1;
        a8 = av; b8 = bv; cin8 = c; sub8 = s; in_valid8 = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready8 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready8) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept8: in_ready=0, expected 1 within 50 cycles");
            in_valid8 = 1'b0;
            return;
        end
        if (expect_it) begin
            e.sum = {8'h00, es}; e.cout = ec; e.ovf = eo; e.acc = cyc + 1;
            q8.push_back(e);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic s,
                           input logic [15:0] es, input logic ec, input logic eo);
        exp_t e;
        int   t;
        @(posedge clk); #1;
        a16 = av; b16 = bv; cin16 = c; sub16 = s; in_valid16 = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready16 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready16) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept16: in_ready=0, expected 1 within 50 cycles");
            in_valid16 = 1'b0;
            return;
        end
        e.sum = es; e.cout = ec; e.ovf = eo; e.acc = cyc + 1;
        q16.push_back(e);
        @(posedge clk); #1;
        in_valid16 = 1'b0;
    endtask

    task automatic wait_idle8();
        int t = 0;
        while (q8.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q8.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain8: %0d results outstanding, expected 0", q8.size());
            q8.delete();
        end
    endtask

    task automatic wait_idle16();
        int t = 0;
        while (q16.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (q16.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain16: %0d results outstanding, expected 0", q16.size());
            q16.delete();
        end
    endtask

    vec_t v8 [0:6];
    vec_t v16 [0:2];

    initial begin
        int  t;
        bit  seen;
        v8 = '{
            '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
            '{16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1},
            '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'h00FE, 1'b0, 1'b0},
            '{16'h0005, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0},
            '{16'h0080, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b1, 1'b1},
            '{16'h000F, 16'h0001, 1'b1, 1'b0, 16'h0011, 1'b0, 1'b0},
            '{16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0}
        };
        v16 = '{
            '{16'h1234, 16'hEDCC, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0},
            '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1},
            '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0}
        };

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready8", in_ready8, 0);
        chk("rst_out_valid8", out_valid8, 0);
        chk("rst_sum8", sum8, 0);
        chk("rst_cout8", cout8, 0);
        chk("rst_ovf8", ovf8, 0);
        chk("rst_in_ready16", in_ready16, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready8_low", in_ready8, 0);
        @(negedge clk);
        chk("post_rst_in_ready8_high", in_ready8, 1);

        // Directed 8-bit vectors
        for (int i = 0; i < 7; i++) begin
            issue8(v8[i].a[7:0], v8[i].b[7:0], v8[i].cin, v8[i].sub, 1'b1,
                   v8[i].sum[7:0], v8[i].cout, v8[i].ovf);
            wait_idle8();
        end

        // Backpressure: hold result in DONE, poke in_valid meanwhile
        out_ready8 = 1'b0;
        issue8(8'h12, 8'h34, 1'b0, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0);
        t = 0;
        while (!out_valid8 && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("bp_out_valid_seen", out_valid8, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            in_valid8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
            @(negedge clk);
            chk("bp_sum", sum8, 32'h46);
            chk("bp_cout", cout8, 0);
            chk("bp_ovf", ovf8, 0);
            chk("bp_in_ready", in_ready8, 0);
            chk("bp_out_valid", out_valid8, 1);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", in_ready8, 1);
        chk("bp_release_out_valid", out_valid8, 0);
        wait_idle8();

        // Reset mid-RUN discards the operation
        issue8(8'h33, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrun_in_ready", in_ready8, 0);
        chk("midrun_out_valid", out_valid8, 0);
        chk("midrun_sum", sum8, 0);
        chk("midrun_cout", cout8, 0);
        chk("midrun_ovf", ovf8, 0);
        @(negedge clk);
        chk("midrun_in_ready_after", in_ready8, 1);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid8) seen = 1'b1;
        end
        chk("midrun_no_out_valid", {31'b0, seen}, 0);
        issue8(8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0);
        wait_idle8();

        // Wide variant
        for (int i = 0; i < 3; i++) begin
            issue16(v16[i].a, v16[i].b, v16[i].cin, v16[i].sub, v16[i].sum, v16[i].cout, v16[i].ovf);
            wait_idle16();
        end

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder/subtractor that computes `a ± b ± cin` over WIDTH bits in BITS_PER_CYCLE-bit slices, LSB first. It uses one ripple slice of bit cells and holds the carry in a register between steps. It sits behind the tile top-level wrapper and takes operands and returns results over valid/ready handshakes. It trades latency for area so wide operands fit the tile.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; ≥ 2.
- BITS_PER_CYCLE, 1, bits processed per RUN cycle. Must divide WIDTH; elaboration error otherwise.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0 = `a + b + cin`; 1 = `a − b − cin`.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry-out of MSB. In sub mode, 1 = no borrow.
- overflow  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- STEPS = WIDTH / BITS_PER_CYCLE.
- FSM states:
  - IDLE: in_ready = 1. On in_valid, latch a, b, sub, cin, go to RUN with step counter = 0.
  - RUN: process one slice per cycle. After slice STEPS−1, go to DONE.
  - DONE: out_valid = 1. On out_ready, go to IDLE.
- Operand latch:
  - Capture a into the A shift register.
  - Capture b into the B shift register; store ~b when sub = 1.
  - Carry register = cin when sub = 0; carry register = ~cin when sub = 1.
- Each RUN cycle:
  - Bit cells add the low BITS_PER_CYCLE bits of A and B plus the carry register.
  - The slice sum shifts into the top of the result register.
  - A and B shift right by BITS_PER_CYCLE.
  - The carry register takes the slice carry-out.
- On the final slice:
  - cout = final carry.
  - overflow = carry into MSB cell XOR carry out of MSB cell.
- sum, cout and overflow are held stable for the whole of DONE. Inputs a, b, cin and sub are ignored outside the IDLE accept.
- Reset:
  - While rst = 1: state IDLE, in_ready = 0, out_valid = 0, sum = 0, cout = 0, overflow = 0, step counter = 0, carry = 0.
  - in_ready goes to 1 in the first cycle after rst deasserts.
- Reset mid-RUN or mid-DONE: the operation is discarded and no out_valid pulse is produced.
- in_valid held high during RUN or DONE has no effect; operands are not queued.

## Timing
- Accept edge: the clk edge with in_valid & in_ready.
- out_valid rises STEPS edges after the accept edge.
  - WIDTH=8, BITS_PER_CYCLE=1: 8 cycles.
  - WIDTH=16, BITS_PER_CYCLE=4: 4 cycles.
- Result handshake edge (out_valid & out_ready): out_valid falls and in_ready rises in the following cycle.
- Minimum issue interval: STEPS + 2 cycles. No back-to-back overlap.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from any input to any output.
- Critical path: one BITS_PER_CYCLE-bit ripple chain.

## Structure
- Shared package `serial_adder_pkg`:
  - state enum: IDLE, RUN, DONE.
  - function computing STEPS.
  - localparam for counter width, $clog2(STEPS+1).
- Sub-module `adder_bit_cell`: combinational 1-bit add, ports a, b, ci, s, co.
  - Instantiated BITS_PER_CYCLE times via generate to form the slice ripple.
  - The MSB-cell carry-in is tapped for overflow.
- Top level holds the FSM, counter, shift registers and carry register.

## Test plan
- Add wrap, WIDTH=8, BITS_PER_CYCLE=1: a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, overflow=0; out_valid exactly 8 cycles after accept.
- Signed overflow: a=0x7F, b=0x01, cin=0, sub=0 -> sum=0x80, cout=0, overflow=1.
- Subtract with borrow: a=0x05, b=0x07, cin=0, sub=1 -> sum=0xFE, cout=0, overflow=0. Also a=0x05, b=0x02, cin=1, sub=1 -> sum=0x02, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum, cout, overflow stable; in_ready stays 0; a new in_valid is ignored. Release out_ready -> in_ready=1 next cycle.
- Reset mid-RUN: assert rst at step 3 for one cycle -> out_valid never rises, all outputs 0; in_ready=1 next cycle. Next op 0x10+0x20 -> 0x30.
- Wide variant, WIDTH=16, BITS_PER_CYCLE=4: a=0x1234, b=0xEDCC, cin=0, sub=0 -> sum=0x0000, cout=1, overflow=0; latency 4 cycles.
